// File: rtl/udp_hdr_parser.sv
// UDP/IPv4/Ethernet header parser: pops frame bytes from an upstream FIFO, extracts
// the IPv4/UDP header fields, streams the UDP payload and keeps accept/drop counters.
module udp_hdr_parser #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in_dout,
    input  logic                 in_sof,
    input  logic                 in_eof,
    input  logic                 in_empty,
    output logic                 in_rd_en,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic                 out_err,
    output logic                 hdr_valid,
    output logic [31:0]          src_ip,
    output logic [31:0]          dst_ip,
    output logic [15:0]          src_port,
    output logic [15:0]          dst_port,
    output logic [15:0]          payload_len,
    output logic [CNT_WIDTH-1:0] pkt_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic [1:0]           dbg_state
);

    // Output handshake: a byte transfers on a rising edge where out_valid && out_ready;
    // out_valid never drops and out_data never changes before that transfer.

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

    state_t      state, state_nxt;
    logic [5:0]  idx;
    logic [15:0] remaining;
    logic        first_byte;
    logic [15:0] eth_type;
    logic [7:0]  ver_ihl;
    logic [7:0]  proto;
    logic [31:0] s_src_ip, s_dst_ip;
    logic [15:0] s_src_port, s_dst_port, udp_len;

    logic pop, hdr_ok, accept, drop_inc, emit, emit_eof, emit_err;

    assign in_rd_en  = !reset && !in_empty && ((state != PAYLOAD) || !out_valid || out_ready);
    assign pop       = in_rd_en;
    assign dbg_state = state;
    assign hdr_ok    = (eth_type == 16'h0800) && (ver_ihl == 8'h45) &&
                       (proto == 8'd17) && (udp_len >= 16'd8);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        drop_inc  = 1'b0;
        emit      = 1'b0;
        emit_eof  = 1'b0;
        emit_err  = 1'b0;
        if (pop) begin
            case (state)
                IDLE: begin
                    if (in_sof) state_nxt = HDR;
                end
                HDR: begin
                    if (in_sof) begin
                        drop_inc  = 1'b1;
                        state_nxt = HDR;
                    end else if (in_eof) begin
                        drop_inc  = 1'b1;
                        state_nxt = IDLE;
                    end else if (idx == 6'd41) begin
                        if (hdr_ok) begin
                            accept    = 1'b1;
                            state_nxt = (udp_len != 16'd8) ? PAYLOAD : DROP;
                        end else begin
                            drop_inc  = 1'b1;
                            state_nxt = DROP;
                        end
                    end
                end
                PAYLOAD: begin
                    if (in_sof) begin
                        drop_inc  = 1'b1;
                        state_nxt = HDR;
                    end else begin
                        emit = 1'b1;
                        if (remaining == 16'd1) begin
                            emit_eof  = 1'b1;
                            state_nxt = in_eof ? IDLE : DROP;
                        end else if (in_eof) begin
                            emit_eof  = 1'b1;
                            emit_err  = 1'b1;
                            drop_inc  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                DROP: begin
                    // The frame in DROP was already counted, either as accepted or as dropped.
                    if (in_sof)      state_nxt = HDR;
                    else if (in_eof) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            remaining   <= '0;
            first_byte  <= 1'b0;
            eth_type    <= '0;
            ver_ihl     <= '0;
            proto       <= '0;
            s_src_ip    <= '0;
            s_dst_ip    <= '0;
            s_src_port  <= '0;
            s_dst_port  <= '0;
            udp_len     <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_sof     <= 1'b0;
            out_eof     <= 1'b0;
            out_err     <= 1'b0;
            hdr_valid   <= 1'b0;
            src_ip      <= '0;
            dst_ip      <= '0;
            src_port    <= '0;
            dst_port    <= '0;
            payload_len <= '0;
            pkt_count   <= '0;
            drop_count  <= '0;
        end else begin
            state     <= state_nxt;
            hdr_valid <= accept;

            // A byte carrying sof is always byte 0 of a fresh frame, whatever the state.
            if (pop && in_sof)              idx <= 6'd1;
            else if (pop && state == HDR)   idx <= idx + 6'd1;

            if (pop && state == HDR && !in_sof) begin
                case (idx)
                    6'd12:                      eth_type[15:8] <= in_dout;
                    6'd13:                      eth_type[7:0]  <= in_dout;
                    6'd14:                      ver_ihl        <= in_dout;
                    6'd23:                      proto          <= in_dout;
                    6'd26, 6'd27, 6'd28, 6'd29: s_src_ip       <= {s_src_ip[23:0], in_dout};
                    6'd30, 6'd31, 6'd32, 6'd33: s_dst_ip       <= {s_dst_ip[23:0], in_dout};
                    6'd34, 6'd35:               s_src_port     <= {s_src_port[7:0], in_dout};
                    6'd36, 6'd37:               s_dst_port     <= {s_dst_port[7:0], in_dout};
                    6'd38, 6'd39:               udp_len        <= {udp_len[7:0], in_dout};
                    default: ;
                endcase
            end

            if (accept) begin
                src_ip      <= s_src_ip;
                dst_ip      <= s_dst_ip;
                src_port    <= s_src_port;
                dst_port    <= s_dst_port;
                payload_len <= udp_len - 16'd8;
                remaining   <= udp_len - 16'd8;
                first_byte  <= 1'b1;
            end else if (emit) begin
                remaining  <= remaining - 16'd1;
                first_byte <= 1'b0;
            end

            if (emit) begin
                out_data  <= in_dout;
                out_valid <= 1'b1;
                out_sof   <= first_byte;
                out_eof   <= emit_eof;
                out_err   <= emit_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
                out_eof   <= 1'b0;
                out_err   <= 1'b0;
            end

            if (accept)   pkt_count  <= pkt_count + CNT_WIDTH'(1);
            if (drop_inc) drop_count <= drop_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_udp_hdr_parser.sv
// Directed bench for udp_hdr_parser: frames built from a byte table, payload checked
// against an expected queue, counters and header fields checked after each frame.
module tb_udp_hdr_parser;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    in_dout = 8'h00;
    logic          in_sof = 1'b0, in_eof = 1'b0, in_empty = 1'b0;
    logic          in_rd_en;
    logic [7:0]    out_data;
    logic          out_valid, out_sof, out_eof, out_err, hdr_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   src_ip, dst_ip;
    logic [15:0]   src_port, dst_port, payload_len;
    logic [CW-1:0] pkt_count, drop_count;
    logic [1:0]    dbg_state;

    logic [9:0]  src_q[$];   // {sof, eof, data}
    logic [11:0] exp_q[$];   // {present, err, eof, sof, data}

    int n_checks = 0, n_fail = 0;
    int hdr_cnt = 0, n_acc = 0, exp_pkt = 0, exp_drop = 0;
    bit gap_en = 0, toggle_en = 0, pend_pop = 0;
    logic [31:0] exp_src_ip, exp_dst_ip;
    logic [15:0] exp_sport, exp_dport, exp_plen;

    udp_hdr_parser #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .in_dout(in_dout), .in_sof(in_sof), .in_eof(in_eof),
        .in_empty(in_empty), .in_rd_en(in_rd_en), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof), .out_err(out_err),
        .hdr_valid(hdr_valid), .src_ip(src_ip), .dst_ip(dst_ip), .src_port(src_port),
        .dst_port(dst_port), .payload_len(payload_len), .pkt_count(pkt_count),
        .drop_count(drop_count), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Build one frame into the source FIFO model and the expected payload queue
    task automatic build_frame(input int len, input logic [15:0] etype, input logic [7:0] prot,
                               input logic [15:0] ulen, input bit with_eof, input int seed);
        logic [7:0]  b;
        logic [31:0] sip, dip;
        logic [15:0] sp, dp;
        int          plen;
        sip = 32'hC0A8_0001 + 32'(seed);
        dip = 32'h0A00_0002 + 32'(seed);
        sp  = 16'd1000 + 16'(seed);
        dp  = 16'd2000 + 16'(seed);
        for (int i = 0; i < len; i++) begin
            b = 8'(i * 13 + seed);
            case (i)
                12: b = etype[15:8];
                13: b = etype[7:0];
                14: b = 8'h45;
                23: b = prot;
                26, 27, 28, 29: b = 8'(sip >> (8 * (29 - i)));
                30, 31, 32, 33: b = 8'(dip >> (8 * (33 - i)));
                34, 35: b = 8'(sp >> (8 * (35 - i)));
                36, 37: b = 8'(dp >> (8 * (37 - i)));
                38, 39: b = 8'(ulen >> (8 * (39 - i)));
                default: ;
            endcase
            src_q.push_back({i == 0, with_eof && (i == len - 1), b});
        end
        if (etype == 16'h0800 && prot == 8'd17 && ulen >= 16'd8 && len > 42) begin
            exp_src_ip = sip; exp_dst_ip = dip; exp_sport = sp; exp_dport = dp;
            plen = int'(ulen) - 8;
            exp_plen = 16'(plen);
            for (int k = 0; k < plen && 42 + k < len; k++) begin
                logic e, r;
                e = (k == plen - 1) || (with_eof && k == len - 43);
                r = e && (k < plen - 1);
                exp_q.push_back({1'b1, r, e, k == 0, 8'((42 + k) * 13 + seed)});
            end
        end
    endtask

    // Driver + monitor: inputs change on the falling edge, outputs sampled 1 ns later
    initial begin
        logic [9:0]  junk;
        logic [11:0] exp_item;
        forever begin
            @(negedge clk);
            if (pend_pop && !reset) junk = src_q.pop_front();
            if (reset) begin
                in_empty = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_dout = 8'h5a;
            end else if (src_q.size() == 0 || (gap_en && $urandom_range(0, 2) == 0)) begin
                in_empty = 1'b1; in_sof = 1'b0; in_eof = 1'b0;
            end else begin
                in_empty = 1'b0;
                {in_sof, in_eof, in_dout} = src_q[0];
            end
            out_ready = toggle_en ? !out_ready : 1'b1;
            #1;
            pend_pop = in_rd_en && !in_empty;
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) exp_item = exp_q.pop_front();
                else                  exp_item = 12'h000;
                check_eq("payload", 64'({1'b1, out_err, out_eof, out_sof, out_data}), 64'(exp_item));
                n_acc++;
            end
            if (hdr_valid) hdr_cnt++;
        end
    end

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #2;
            if (src_q.size() == 0 && !pend_pop && !out_valid) break;
        end
        repeat (3) @(negedge clk);
        #2;
        check_eq({tag, "_drained"}, 64'(src_q.size()), 64'd0);
    endtask

    task automatic end_test(input string tag, input int exp_hdr);
        wait_done(tag);
        check_eq({tag, "_pkt"},  64'(pkt_count), 64'(exp_pkt));
        check_eq({tag, "_drop"}, 64'(drop_count), 64'(exp_drop));
        check_eq({tag, "_hdr"},  64'(hdr_cnt), 64'(exp_hdr));
        check_eq({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        hdr_cnt = 0;
    endtask

    task automatic check_fields(input string tag);
        check_eq({tag, "_sip"},  64'(src_ip), 64'(exp_src_ip));
        check_eq({tag, "_dip"},  64'(dst_ip), 64'(exp_dst_ip));
        check_eq({tag, "_sp"},   64'(src_port), 64'(exp_sport));
        check_eq({tag, "_dp"},   64'(dst_port), 64'(exp_dport));
        check_eq({tag, "_plen"}, 64'(payload_len), 64'(exp_plen));
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_rd_en"}, 64'(in_rd_en), 64'd0);
        check_eq({tag, "_outs"},  64'({out_valid, out_sof, out_eof, out_err, hdr_valid}), 64'd0);
        check_eq({tag, "_flds"},  64'({src_ip, dst_ip} | 64'({src_port, dst_port})), 64'd0);
        check_eq({tag, "_plen"},  64'(payload_len), 64'd0);
        check_eq({tag, "_cnts"},  64'({pkt_count, drop_count}), 64'd0);
        check_eq({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    initial begin
        #2;
        check_zero("reset");
        @(posedge clk); #1 reset = 1'b0;

        build_frame(50, 16'h0800, 8'd17, 16'd16, 1'b1, 1);
        exp_pkt++;
        end_test("basic", 1);
        check_fields("basic");

        build_frame(50, 16'h86DD, 8'd17, 16'd16, 1'b1, 2);
        exp_drop++;
        build_frame(50, 16'h0800, 8'd17, 16'd16, 1'b1, 3);
        exp_pkt++;
        end_test("ipv6", 1);
        check_fields("ipv6_next");

        build_frame(64, 16'h0800, 8'd17, 16'd20, 1'b1, 4);
        exp_pkt++;
        end_test("pad", 1);
        check_eq("pad_idle", 64'(dbg_state), 64'd0);

        build_frame(60, 16'h0800, 8'd17, 16'd100, 1'b1, 5);
        exp_pkt++; exp_drop++;
        end_test("trunc", 1);

        build_frame(60, 16'h0800, 8'd17, 16'd8, 1'b1, 6);
        exp_pkt++;
        end_test("zero_len", 1);
        check_eq("zero_len_plen", 64'(payload_len), 64'd0);

        build_frame(60, 16'h0800, 8'd17, 16'd4, 1'b1, 7);
        exp_drop++;
        build_frame(60, 16'h0800, 8'd6, 16'd20, 1'b1, 8);
        exp_drop++;
        build_frame(30, 16'h0800, 8'd17, 16'd20, 1'b1, 9);
        exp_drop++;
        end_test("rejects", 0);

        build_frame(50, 16'h0800, 8'd17, 16'd40, 1'b0, 10);
        build_frame(52, 16'h0800, 8'd17, 16'd18, 1'b1, 11);
        exp_pkt += 2; exp_drop++;
        end_test("sof_abort", 2);
        check_fields("sof_abort");

        toggle_en = 1; gap_en = 1;
        build_frame(80, 16'h0800, 8'd17, 16'd40, 1'b1, 12);
        build_frame(70, 16'h0800, 8'd17, 16'd28, 1'b1, 13);
        exp_pkt += 2;
        end_test("bp", 2);
        toggle_en = 0; gap_en = 0;

        n_acc = 0;
        build_frame(90, 16'h0800, 8'd17, 16'd40, 1'b1, 14);
        for (int i = 0; i < 500 && n_acc < 5; i++) @(negedge clk);
        check_eq("rst_wait", 64'(n_acc >= 5), 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        #1;
        check_zero("midrst");
        src_q.delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        exp_pkt = 0; exp_drop = 0; hdr_cnt = 0;
        build_frame(50, 16'h0800, 8'd17, 16'd16, 1'b1, 15);
        exp_pkt++;
        end_test("post_rst", 1);
        check_fields("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
